// File: rtl/calc_accumulator_seq_if.sv
// Operand/opcode request and result bus between the calculator input logic
// and the accumulator sequencer.
interface calc_accumulator_seq_if #(
    parameter int n = 4
);
    logic           start;
    logic [1:0]     op;
    logic [n-1:0]   operand;
    logic [n-1:0]   acc;
    logic [2*n-1:0] result;
    logic           carry;
    logic           overflow;
    logic           busy;
    logic           done;

    modport master (
        output start, op, operand,
        input  acc, result, carry, overflow, busy, done
    );

    modport slave (
        input  start, op, operand,
        output acc, result, carry, overflow, busy, done
    );
endinterface

// File: rtl/calc_accumulator_seq.sv
// Accumulator sequencer: LOAD/ADD/SUB in one cycle, unsigned MUL as an n-step
// shift-add, all arithmetic through a single shared adder_subtractor.
module adder_subtractor #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    output logic [n-1:0] s,
    output logic         c_out,
    output logic         overflow
);
    logic [n-1:0] y_eff;

    // Subtraction is x + ~y + 1, so c_out=1 means "no borrow".
    assign y_eff             = y ^ {n{add_n}};
    assign {c_out, s}        = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
    assign overflow          = (x[n-1] == y_eff[n-1]) && (s[n-1] != x[n-1]);
endmodule

module calc_accumulator_seq #(
    parameter int n = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    calc_accumulator_seq_if.slave  bus
);
    localparam int CW = $clog2(n) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_MUL} op_e;

    state_e         state, state_next;
    op_e            op_q;
    logic [n-1:0]   operand_q;
    logic [n-1:0]   acc_q;
    logic [n-1:0]   hi_q;
    logic           carry_q;
    logic           ovf_q;
    logic [n-1:0]   m_q;       // multiplicand
    logic [n-1:0]   l_q;       // multiplier, shifts out as product low half fills in
    logic [n-1:0]   ph_q;      // partial-product upper half, private until commit
    logic [CW-1:0]  count_q;

    logic [n-1:0]   add_x, add_y, add_s;
    logic           add_sub, add_c, add_v;
    logic           busy_c, done_c;
    logic [n:0]     step_sum;
    logic [2*n-1:0] step_next;
    logic           last_step;

    adder_subtractor #(.n(n)) u_addsub (
        .x        (add_x),
        .y        (add_y),
        .add_n    (add_sub),
        .s        (add_s),
        .c_out    (add_c),
        .overflow (add_v)
    );

    // One shift-add step: {c,sum,L} >> 1.
    assign step_sum  = l_q[0] ? {add_c, add_s} : {1'b0, ph_q};
    assign step_next = {step_sum, l_q[n-1:1]};
    assign last_step = (count_q == CW'(n - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = (op_e'(bus.op) == OP_MUL) ? MUL : EXEC;
            EXEC: state_next = DONE;
            MUL:  if (last_step) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / adder-steering logic.
    always_comb begin
        busy_c  = (state != IDLE);
        done_c  = (state == DONE);
        add_x   = acc_q;
        add_y   = operand_q;
        add_sub = 1'b0;
        if (state == MUL) begin
            add_x = ph_q;
            add_y = m_q;
        end else if (state == EXEC) begin
            add_sub = (op_q == OP_SUB);
        end
    end

    // Datapath registers.
    // NOTE: every datapath register is reset, since acc/result are visible immediately after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_LOAD;
            operand_q <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            m_q       <= '0;
            l_q       <= '0;
            ph_q      <= '0;
            count_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q      <= op_e'(bus.op);
                        operand_q <= bus.operand;
                        if (op_e'(bus.op) == OP_MUL) begin
                            m_q     <= acc_q;
                            l_q     <= bus.operand;
                            ph_q    <= '0;
                            count_q <= '0;
                        end
                    end
                end
                EXEC: begin
                    hi_q <= '0;
                    if (op_q == OP_LOAD) begin
                        acc_q   <= operand_q;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        acc_q   <= add_s;
                        carry_q <= add_c;
                        ovf_q   <= add_v;
                    end
                end
                MUL: begin
                    {ph_q, l_q} <= step_next;
                    count_q     <= count_q + CW'(1);
                    if (last_step) begin
                        acc_q   <= step_next[n-1:0];
                        hi_q    <= step_next[2*n-1:n];
                        carry_q <= 1'b0;
                        ovf_q   <= |step_next[2*n-1:n];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.acc      = acc_q;
    assign bus.result   = {hi_q, acc_q};
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
endmodule
